// File: rtl/crc_transmitter.sv
// Bit-serial CRC encoder: accepts a BW-bit word, emits the codeword {data, remainder} under valid/ready.
// Optional single-bit error injection on out[0] when CRC_TX_ERR_INJ_EN is defined.
module crc_transmitter #(
   parameter int                BW      = 4,
   parameter int                CRC_BW  = 3,
   parameter logic [CRC_BW:0]   DIVISOR = 4'b1011
) (
   input  logic                 clk,
   input  logic                 rstn,
   input  logic [BW-1:0]        in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   output logic [BW+CRC_BW-1:0] out,
   output logic                 out_valid,
`ifdef CRC_TX_ERR_INJ_EN
   input  logic                 err_inj,
`endif
   input  logic                 out_ready
);

   localparam int W     = BW + CRC_BW;
   localparam int CNT_W = (BW > 1) ? $clog2(BW) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

   state_t              state, state_nxt;
   logic [BW-1:0]       shreg, shreg_nxt;
   logic [BW-1:0]       data_q, data_nxt;
   logic [CRC_BW-1:0]   rem, rem_nxt, rem_step;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic [W-1:0]        out_nxt;
   logic                out_valid_nxt;
   logic                fb;

   assign in_ready = (state == IDLE);

   always_comb begin
      state_nxt     = state;
      shreg_nxt     = shreg;
      data_nxt      = data_q;
      rem_nxt       = rem;
      cnt_nxt       = cnt;
      out_nxt       = out;
      out_valid_nxt = out_valid;

      // One LFSR step with the implicit leading 1 of the divisor folded into the feedback
      fb       = shreg[BW-1] ^ rem[CRC_BW-1];
      rem_step = {rem[CRC_BW-2:0], 1'b0} ^ (fb ? DIVISOR[CRC_BW-1:0] : '0);

      unique case (state)
         IDLE: begin
            if (in_valid) begin
               shreg_nxt = in_data;
               data_nxt  = in_data;
               rem_nxt   = '0;
               cnt_nxt   = '0;
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            rem_nxt   = rem_step;
            shreg_nxt = shreg << 1;
            cnt_nxt   = cnt + CNT_W'(1);
            if (cnt == CNT_W'(BW - 1)) begin
               out_nxt       = {data_q, rem_step};
`ifdef CRC_TX_ERR_INJ_EN
               if (err_inj) out_nxt[0] = ~out_nxt[0];
`endif
               out_valid_nxt = 1'b1;
               state_nxt     = HOLD;
            end
         end
         HOLD: begin
            if (out_valid && out_ready) begin
               out_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= IDLE;
         shreg     <= '0;
         data_q    <= '0;
         rem       <= '0;
         cnt       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         shreg     <= shreg_nxt;
         data_q    <= data_nxt;
         rem       <= rem_nxt;
         cnt       <= cnt_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
      end
   end

endmodule

// File: doc/crc_transmitter.md
# crc_transmitter

Serial CRC encoder on the transmit side of the CRC_N link. Accepts a BW-bit data word over a valid/ready handshake, computes the CRC_BW-bit remainder of data·x^CRC_BW modulo DIVISOR with a bit-serial LFSR (MSB first), and presents the codeword {data, remainder} on a registered output held under a valid/ready handshake. The codeword format is exactly what the CRC_N receiver checks: a zero syndrome means a clean word.

## Interface
- BW, default 4: data word width, ≥ 1.
- CRC_BW, default 3: CRC width, ≥ 2.
- DIVISOR, default 4'b1011: generator polynomial, CRC_BW+1 bits. The MSB must be 1 and is implicit in the LFSR.

- clk, input, 1: clock. All state changes on the rising edge.
- rstn, input, 1: reset. Synchronous, active-low.
- in_data, input, BW: data word to encode.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word. High only in IDLE, decoded from state.
- out, output, BW+CRC_BW: codeword. out[BW+CRC_BW-1:CRC_BW] is data; out[CRC_BW-1:0] is the CRC.
- out_valid, output, 1: out holds a new codeword.
- out_ready, input, 1: sink accepts the codeword.
- err_inj, input, 1: error-injection request. Present only with CRC_TX_ERR_INJ_EN.

## Operation
- **States**
  - IDLE: in_ready=1. On in_valid && in_ready, capture in_data into the shift register, clear rem to 0, clear bit counter cnt to 0, and go to SHIFT.
  - SHIFT: each cycle consume data bit d = shreg[BW-1].
    - fb = d ^ rem[CRC_BW-1].
    - rem ← {rem[CRC_BW-2:0],1'b0} ^ (fb ? DIVISOR[CRC_BW-1:0] : 0).
    - shreg shifts left.
    - cnt increments.
    - On the cycle where cnt == BW-1: load out ← {captured data, next rem}, set out_valid=1, go to HOLD.
  - HOLD: out and out_valid are held stable. On out_valid && out_ready, clear out_valid and go to IDLE.
- **Captured data**: a separate copy of the accepted word is kept, so out[high] equals the accepted in_data exactly.
- **Input changes after acceptance**: in_data and in_valid are ignored outside IDLE. Input changes during SHIFT or HOLD have no effect.
- **Remainder**: the result equals the GF(2) remainder of {data, CRC_BW'b0} / DIVISOR.
- **Reset**: applies in any state, including mid-SHIFT and mid-HOLD. Next state is IDLE; out=0, out_valid=0, rem=0, cnt=0, shreg=0. in_ready reads 1 from the first cycle after the reset edge. Any word in flight is discarded with no partial output.
- **out after handshake**: keeps its last value; only out_valid drops.
- **Overlap**: no overlap; a new word is accepted only after the previous codeword is taken.

## Timing
- Acceptance edge A (in_valid && in_ready). out_valid is 1 and out is valid after edge A+BW, i.e. BW cycles of latency (4 for defaults).
- in_ready is 0 from after edge A until after the out handshake edge.
- Earliest next acceptance is the edge after the out handshake edge.
- Maximum throughput is one word per BW+2 cycles, with out_ready tied high.
- out_ready is sampled only while out_valid=1.
- All outputs are registered except in_ready, which is a pure state decode with no combinational path from any input.

## Configuration
- **CRC_TX_ERR_INJ_EN**
  - Defined: port err_inj exists. err_inj is sampled on the cycle out is loaded (last SHIFT cycle). If it is 1, out[0] is inverted in the loaded codeword, producing a single-bit error the receiver must detect. Other behaviour is unchanged.
  - Undefined: no err_inj port, and out is always the correct codeword.

## Test plan
- **Reset**: rstn=0 for 2 cycles with random inputs -> out=7'b0000000, out_valid=0, in_ready=1 after release.
- **Known vectors** (defaults, out_ready=1):
  - in_data 4'b1101 -> out=7'b1101001.
  - 4'b1000 -> 7'b1000101.
  - 4'b1111 -> 7'b1111111.
  - 4'b0000 -> 7'b0000000.
  - Each with out_valid rising exactly 4 cycles after acceptance.
- **Backpressure**: out_ready=0 for 10 cycles after out_valid -> out stable at 7'b1101001, in_ready=0, and a new in_valid is not accepted. Raise out_ready -> one handshake, out_valid=0, in_ready=1 the next cycle.
- **Mid-operation reset**: accept 4'b1011, assert rstn=0 after 2 SHIFT cycles -> out_valid never rises and out=0. Then 4'b1000 encodes to 7'b1000101 correctly.
- **Exhaustive loopback**: all 16 words through crc_transmitter into the CRC_N receiver -> receiver output equals the original data each time.
- **Error injection** (CRC_TX_ERR_INJ_EN defined): err_inj=1 with 4'b1101 -> out=7'b1101000, and the receiver outputs 4'b0000.
